// File: rtl/booth_pkg.sv
// Shared constants and FSM encoding for the Booth multiplier pipeline controller.
package booth_pkg;

  localparam int BOOTH_STAGES_DEF = 4;
  localparam int OP_W             = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } booth_state_e;

endpackage

// File: rtl/booth_perf_cnt.sv
// Saturating event counter: increments on inc_i and holds at all-ones; cleared by reset only.
module booth_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/booth_pipe_ctrl.sv
// Valid/ready sequencer for a STAGES-deep Booth pipeline with flush, drain and stall freeze.
// Define BOOTH_CTRL_PERF_EN to add the done_cnt/stall_cnt performance counters.
module booth_pipe_ctrl
  import booth_pkg::*;
#(
  parameter int STAGES = BOOTH_STAGES_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [STAGES-1:0]            load,
  input  logic                         flush,
  input  logic                         drain_req,
  output logic                         drain_done,
  output logic [$clog2(STAGES+1)-1:0]  occ,
  output logic                         busy
`ifdef BOOTH_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]             done_cnt,
  output logic [CNT_W-1:0]             stall_cnt
`endif
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] v_q, v_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  booth_state_e      state_q, state_d;
  logic              drain_done_q, drain_done_d;
  logic              stall, adv, accept, retire;

  // A stalled head freezes every stage at once; no bubbles are squeezed out.
  assign out_valid = v_q[STAGES-1];
  assign stall     = v_q[STAGES-1] & ~out_ready;
  assign adv       = ~stall & ~flush;
  assign in_ready  = adv & (state_q == RUN);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign load      = {v_q[STAGES-2:0], accept} & {STAGES{adv}};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else if (adv) begin
      v_d = {v_q[STAGES-2:0], accept};
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !retire) begin
      occ_d = occ_q + 1'b1;
    end else if (retire && !accept) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // A flush during DRAIN empties the pipe, so the drain completes on that same edge.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      IDLE:    if (!drain_req) state_d = RUN;
      RUN:     if (drain_req)  state_d = DRAIN;
      DRAIN: begin
        if ((occ_q == '0) || flush) begin
          state_d      = IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q          <= '0;
      occ_q        <= '0;
      state_q      <= IDLE;
      drain_done_q <= 1'b0;
    end else begin
      v_q          <= v_d;
      occ_q        <= occ_d;
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign occ        = occ_q;
  assign busy       = (occ_q != '0);
  assign drain_done = drain_done_q;

`ifdef BOOTH_CTRL_PERF_EN
  booth_perf_cnt #(.W(CNT_W)) u_done_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (retire),
    .cnt_o (done_cnt)
  );

  booth_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (stall),
    .cnt_o (stall_cnt)
  );
`else
  // Counters and their ports are absent in this build.
`endif

endmodule

// File: tb/tb_booth_pipe_ctrl.sv
// Self-checking bench for booth_pipe_ctrl: queue-of-positions reference model plus directed literal checks.
module tb_booth_pipe_ctrl;
  import booth_pkg::*;

  localparam int S  = 4;
  localparam int CW = 16;
  localparam int OW = $clog2(S+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, drain_req = 1'b0;
  logic          in_ready, out_valid, drain_done, busy;
  logic [S-1:0]  load;
  logic [OW-1:0] occ;
`ifdef BOOTH_CTRL_PERF_EN
  logic [CW-1:0] done_cnt, stall_cnt;
`endif

  booth_pipe_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .load       (load),
    .flush      (flush),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .occ        (occ),
    .busy       (busy)
`ifdef BOOTH_CTRL_PERF_EN
    ,
    .done_cnt   (done_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each in-flight operation is its current stage index, oldest first.
  typedef enum {M_IDLE, M_RUN, M_DRAIN} m_state_t;
  int       pipe[$];
  m_state_t m_state = M_IDLE;
  bit       m_done  = 1'b0;
  int       m_done_cnt = 0, m_stall_cnt = 0;
  localparam int SAT = (1 << CW) - 1;

  logic         obs_ir, obs_ov, obs_done;
  logic [S-1:0] obs_load;
  int           obs_occ;

  task automatic step(input bit iv, input bit ordy, input bit fl, input bit dr);
    logic [S-1:0] e_load;
    bit e_ov, e_stall, e_adv, e_ir, e_acc;
    int occ_now;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl; drain_req = dr;
    #1;
    occ_now = pipe.size();
    e_ov    = (occ_now > 0) && (pipe[0] == S-1);
    e_stall = e_ov && !ordy;
    e_adv   = !e_stall && !fl;
    e_ir    = e_adv && (m_state == M_RUN);
    e_acc   = e_ir && iv;
    e_load  = '0;
    foreach (pipe[i]) if (pipe[i] < S-1) e_load[pipe[i]+1] = e_adv;
    e_load[0] = e_acc;
    check("in_ready",   in_ready,   e_ir);
    check("out_valid",  out_valid,  e_ov);
    check("load",       load,       e_load);
    check("occ",        occ,        occ_now);
    check("busy",       busy,       occ_now != 0);
    check("drain_done", drain_done, m_done);
`ifdef BOOTH_CTRL_PERF_EN
    check("done_cnt",  done_cnt,  m_done_cnt);
    check("stall_cnt", stall_cnt, m_stall_cnt);
`endif
    obs_ir = in_ready; obs_ov = out_valid; obs_load = load; obs_occ = int'(occ); obs_done = drain_done;
    @(posedge clk);
    if (e_ov && ordy && m_done_cnt < SAT) m_done_cnt++;
    if (e_stall && m_stall_cnt < SAT) m_stall_cnt++;
    m_done = 1'b0;
    case (m_state)
      M_IDLE:  if (!dr) m_state = M_RUN;
      M_RUN:   if (dr)  m_state = M_DRAIN;
      default: if (occ_now == 0 || fl) begin m_state = M_IDLE; m_done = 1'b1; end
    endcase
    if (fl) begin
      pipe.delete();
    end else if (e_adv) begin
      if (e_ov) void'(pipe.pop_front());
      foreach (pipe[i]) pipe[i]++;
      if (e_acc) pipe.push_back(0);
    end
  endtask

  // Asserts reset between clock edges, checks outputs immediately, releases just after a rising edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; drain_req = 1'b0;
    #1;
    check("rst_in_ready",   in_ready,   0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_load",       load,       0);
    check("rst_occ",        occ,        0);
    check("rst_busy",       busy,       0);
    check("rst_drain_done", drain_done, 0);
`ifdef BOOTH_CTRL_PERF_EN
    check("rst_done_cnt",  done_cnt,  0);
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    pipe.delete();
    m_state = M_IDLE; m_done = 1'b0; m_done_cnt = 0; m_stall_cnt = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin : main
    int acc_cnt, ov_cnt, acc_first, ov_first, occ_max, done_pulses;
    bit dr;
`ifdef BOOTH_CTRL_PERF_EN
    logic [CW-1:0] stall_before;
`endif

    apply_reset();
    step(1, 1, 0, 0);
    check("first_cycle_in_ready", obs_ir, 0);
    check("first_cycle_load", obs_load, 0);
    check("first_cycle_out_valid", obs_ov, 0);

    // Streaming: 10 operands back to back, consumer always ready.
    acc_cnt = 0; ov_cnt = 0; acc_first = -1; ov_first = -1; occ_max = 0;
    for (int i = 0; i < 18; i++) begin
      step(i < 10, 1, 0, 0);
      if (obs_load[0]) begin acc_cnt++; if (acc_first < 0) acc_first = i; end
      if (obs_ov)      begin ov_cnt++;  if (ov_first < 0)  ov_first = i;  end
      if (obs_occ > occ_max) occ_max = obs_occ;
    end
    check("stream_load0_cycles", acc_cnt, 10);
    check("stream_out_valid_cycles", ov_cnt, 10);
    check("stream_latency", ov_first - acc_first, S);
    check("stream_occ_peak", occ_max, 4);

    // Full pipe with the consumer stalled for three cycles.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
`ifdef BOOTH_CTRL_PERF_EN
    stall_before = stall_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check("stall_load", obs_load, 0);
      check("stall_in_ready", obs_ir, 0);
      check("stall_occ", obs_occ, 4);
    end
`ifdef BOOTH_CTRL_PERF_EN
    #1 check("stall_cnt_delta", stall_cnt - stall_before, 3);
`endif
    ov_cnt = 0;
    for (int i = 0; i < 6; i++) begin step(0, 1, 0, 0); if (obs_ov) ov_cnt++; end
    check("stall_resume_retires", ov_cnt, 4);

    // Flush with three operations in flight while a new operand is offered.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    check("flush_occ_before", obs_occ, 3);
    check("flush_in_ready", obs_ir, 0);
    check("flush_load", obs_load, 0);
    step(0, 1, 0, 0);
    check("flush_occ_after", obs_occ, 0);
    check("flush_out_valid_after", obs_ov, 0);

    // Drain with two operations in flight.
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 1);
    done_pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 1);
      if (i == 0) check("drain_in_ready", obs_ir, 0);
      if (obs_done) done_pulses++;
    end
    check("drain_done_pulses", done_pulses, 1);
    check("drain_idle_in_ready", obs_ir, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("drain_rerun_in_ready", obs_ir, 1);

    // Randomised traffic against the model.
    dr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      dr = ($urandom_range(0, 99) < 4) ? 1'b1 : (dr && ($urandom_range(0, 3) != 0));
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, dr);
    end

    // Reset in the middle of a full, stalled stream.
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    apply_reset();
    step(1, 1, 0, 0);
    check("rst_mid_first_in_ready", obs_ir, 0);
    check("rst_mid_first_out_valid", obs_ov, 0);
    ov_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0);
      if (i == 0) check("rst_mid_second_in_ready", obs_ir, 1);
      if (obs_ov) ov_cnt++;
    end
    check("rst_mid_no_stale_output", ov_cnt, 0);

`ifdef BOOTH_CTRL_PERF_EN
    for (int i = 0; i < 70000 + S; i++) step(1, 1, 0, 0);
    #1 check("done_cnt_saturated", done_cnt, 65535);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
